// File: rtl/updown_pkg.sv
// Shared definitions for the updown counter and its sweep sequencer.
// Holds the default data width and the sequencer state encoding.
package updown_pkg;

    localparam int UPDOWN_W = 4;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_UP   = 3'd2;
    localparam logic [2:0] ST_DOWN = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        LOAD = ST_LOAD,
        UP   = ST_UP,
        DOWN = ST_DOWN,
        DONE = ST_DONE
    } state_t;

endpackage

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer driving an updown counter between lo and hi for reps sweeps.
// Turnarounds are decided from the counter's own count feedback.
module updown_sweep_ctrl
    import updown_pkg::*;
#(
    parameter int W = UPDOWN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         stop,
    input  logic [W-1:0] lo,
    input  logic [W-1:0] hi,
    input  logic [W-1:0] reps,
    input  logic [W-1:0] count,
    output logic         load,
    output logic         mode,
    output logic [W-1:0] a,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [W-1:0] sweeps
);

    state_t       state;
    state_t       state_n;
    logic [W-1:0] lo_q;
    logic [W-1:0] hi_q;
    logic [W-1:0] reps_q;
    logic [W-1:0] sweeps_inc;
    logic         reject;
    logic         accept;
    logic         abort;
    logic         at_hi;
    logic         at_lo;
    logic         last;

    assign reject     = start && ((lo >= hi) || (reps == '0));
    assign accept     = start && !reject;
    assign abort      = (state != IDLE) && stop;
    assign at_hi      = (count == hi_q);
    assign at_lo      = (count == lo_q);
    assign sweeps_inc = sweeps + W'(1);
    assign last       = (sweeps_inc == reps_q);

    // Counter controls: parked at zero unless actively sweeping
    always_comb begin
        load = 1'b1;
        mode = 1'b0;
        a    = '0;
        busy = (state != IDLE);
        if (!abort) begin
            unique case (state)
                IDLE: begin
                    load = 1'b1;
                end
                LOAD: begin
                    a = lo_q;
                end
                UP: begin
                    load = 1'b0;
                    mode = at_hi;
                end
                DOWN: begin
                    if (at_lo && last) begin
                        load = 1'b1;
                    end else begin
                        load = 1'b0;
                        mode = !at_lo;
                    end
                end
                DONE: begin
                    load = 1'b1;
                end
                default: begin
                    load = 1'b1;
                end
            endcase
        end
    end

    // Next state; stop aborts any active run back to idle
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = LOAD;
            end
            LOAD: begin
                state_n = UP;
            end
            UP: begin
                if (at_hi) state_n = DOWN;
            end
            DOWN: begin
                if (at_lo) state_n = last ? DONE : UP;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
        if (abort) state_n = IDLE;
    end

    // State, latched bounds, sweep count and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            lo_q   <= '0;
            hi_q   <= '0;
            reps_q <= '0;
            sweeps <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state <= state_n;
            done  <= (state_n == DONE);
            err   <= (state == IDLE) && reject;
            if ((state == IDLE) && accept) begin
                lo_q   <= lo;
                hi_q   <= hi;
                reps_q <= reps;
                sweeps <= '0;
            end else if ((state == DOWN) && at_lo && !stop) begin
                sweeps <= sweeps_inc;
            end
        end
    end

endmodule

// File: tb/tb_updown_sweep_ctrl.sv
// Directed bench for updown_sweep_ctrl with a behavioural updown counter.
// Per-cycle vectors plus hand-written reset-mid-run sequence.
module tb_updown_sweep_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       stop;
    logic [3:0] lo;
    logic [3:0] hi;
    logic [3:0] reps;
    logic [3:0] cnt;
    logic       load;
    logic       mode;
    logic [3:0] a;
    logic       busy;
    logic       done;
    logic       err;
    logic [3:0] sweeps;

    int n_vec;
    int n_bad;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic [3:0] lo;
        logic [3:0] hi;
        logic [3:0] reps;
        bit         chk;
        logic [3:0] cnt;
        logic       ld;
        int         md;
        logic       busy;
        logic       done;
        logic       err;
        logic [3:0] sw;
    } vec_t;

    vec_t vq[$];

    updown_sweep_ctrl #(.W(4)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .stop(stop),
        .lo(lo),
        .hi(hi),
        .reps(reps),
        .count(cnt),
        .load(load),
        .mode(mode),
        .a(a),
        .busy(busy),
        .done(done),
        .err(err),
        .sweeps(sweeps)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural updown counter fed by the sequencer
    always_ff @(posedge clk) begin
        if (load) cnt <= a;
        else if (mode) cnt <= cnt - 4'd1;
        else cnt <= cnt + 4'd1;
    end

    task automatic cmp(string name, int idx, logic [31:0] got, logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %0d want %0d", name, idx, got, exp);
        end
    endtask

    function automatic void add(logic r, logic s, logic p,
                                logic [3:0] l, logic [3:0] h, logic [3:0] n,
                                bit c, logic [3:0] cn, logic ld, int md,
                                logic b, logic d, logic e, logic [3:0] sw);
        vq.push_back('{r, s, p, l, h, n, c, cn, ld, md, b, d, e, sw});
    endfunction

    function automatic void idle(logic [3:0] sw, logic e);
        add(0, 0, 0, 0, 0, 0, 1, 4'd0, 1, 0, 0, 0, e, sw);
    endfunction

    function automatic void rv(logic [3:0] cn, logic ld, int md,
                               logic d, logic [3:0] sw);
        add(0, 0, 0, 0, 0, 0, 1, cn, ld, md, 1, d, 0, sw);
    endfunction

    initial begin
        int found;
        int n;

        n_vec = 0;
        n_bad = 0;
        rst   = 1'b1;
        start = 1'b0;
        stop  = 1'b0;
        lo    = '0;
        hi    = '0;
        reps  = '0;

        // reset for two cycles, then idle check
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        idle(0, 0);

        // lo=2 hi=5 reps=2, with a mid-run start and bound changes
        add(0, 1, 0, 2, 5, 2, 1, 0, 1, 0, 0, 0, 0, 0);
        rv(0, 1, 0, 0, 0);
        rv(2, 0, 0, 0, 0);
        rv(3, 0, 0, 0, 0);
        rv(4, 0, 0, 0, 0);
        rv(5, 0, 1, 0, 0);
        add(0, 1, 0, 9, 1, 0, 1, 4, 0, 1, 1, 0, 0, 0);
        rv(3, 0, 1, 0, 0);
        rv(2, 0, 0, 0, 0);
        rv(3, 0, 0, 0, 1);
        rv(4, 0, 0, 0, 1);
        rv(5, 0, 1, 0, 1);
        rv(4, 0, 1, 0, 1);
        rv(3, 0, 1, 0, 1);
        rv(2, 1, -1, 0, 1);
        rv(0, 1, -1, 1, 2);
        idle(2, 0);

        // rejected starts
        add(0, 1, 0, 7, 7, 1, 1, 0, 1, 0, 0, 0, 0, 2);
        idle(2, 1);
        idle(2, 0);
        add(0, 1, 0, 1, 9, 0, 1, 0, 1, 0, 0, 0, 0, 2);
        idle(2, 1);
        idle(2, 0);
        add(0, 1, 0, 9, 3, 2, 1, 0, 1, 0, 0, 0, 0, 2);
        idle(2, 1);
        idle(2, 0);

        // minimum span, start with stop in idle
        add(0, 1, 1, 3, 4, 1, 1, 0, 1, 0, 0, 0, 0, 2);
        rv(0, 1, 0, 0, 0);
        rv(3, 0, 0, 0, 0);
        rv(4, 0, 1, 0, 0);
        rv(3, 1, -1, 0, 0);
        rv(0, 1, -1, 1, 1);
        idle(1, 0);

        // stop during second sweep while UP at 4
        add(0, 1, 0, 2, 8, 3, 1, 0, 1, 0, 0, 0, 0, 1);
        rv(0, 1, 0, 0, 0);
        for (int k = 2; k <= 7; k++) rv(4'(k), 0, 0, 0, 0);
        rv(8, 0, 1, 0, 0);
        for (int k = 7; k >= 3; k--) rv(4'(k), 0, 1, 0, 0);
        rv(2, 0, 0, 0, 0);
        rv(3, 0, 0, 0, 1);
        add(0, 0, 1, 0, 0, 0, 1, 4, 1, -1, 1, 0, 0, 1);
        idle(1, 0);
        idle(1, 0);

        // full range 0..15, no wrap at the top
        add(0, 1, 0, 0, 15, 1, 1, 0, 1, 0, 0, 0, 0, 1);
        rv(0, 1, 0, 0, 0);
        for (int k = 0; k <= 14; k++) rv(4'(k), 0, 0, 0, 0);
        rv(15, 0, 1, 0, 0);
        for (int k = 14; k >= 1; k--) rv(4'(k), 0, 1, 0, 0);
        rv(0, 1, -1, 0, 0);
        rv(0, 1, -1, 1, 1);
        idle(1, 0);

        foreach (vq[i]) begin
            @(negedge clk);
            rst   = vq[i].rst;
            start = vq[i].start;
            stop  = vq[i].stop;
            lo    = vq[i].lo;
            hi    = vq[i].hi;
            reps  = vq[i].reps;
            #1;
            if (vq[i].chk) begin
                cmp("count", i, 32'(cnt), 32'(vq[i].cnt));
                cmp("load", i, 32'(load), 32'(vq[i].ld));
                if (vq[i].md >= 0) cmp("mode", i, 32'(mode), vq[i].md);
                cmp("busy", i, 32'(busy), 32'(vq[i].busy));
                cmp("done", i, 32'(done), 32'(vq[i].done));
                cmp("err", i, 32'(err), 32'(vq[i].err));
                cmp("sweeps", i, 32'(sweeps), 32'(vq[i].sw));
            end
        end

        // reset during DOWN of the second sweep
        @(negedge clk);
        start = 1'b1;
        lo    = 4'd2;
        hi    = 4'd6;
        reps  = 4'd2;
        stop  = 1'b0;
        @(negedge clk);
        start = 1'b0;
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            #1;
            if (busy && !load && mode && sweeps == 4'd1) found = 1;
            else @(negedge clk);
        end
        cmp("down2_reached", 0, 32'(found), 32'd1);
        start = 1'b1;
        stop  = 1'b1;
        lo    = 4'd1;
        hi    = 4'd3;
        reps  = 4'd1;
        rst   = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
        #1;
        cmp("rst_load", 0, 32'(load), 32'd1);
        cmp("rst_a", 0, 32'(a), 32'd0);
        cmp("rst_mode", 0, 32'(mode), 32'd0);
        cmp("rst_busy", 0, 32'(busy), 32'd0);
        cmp("rst_done", 0, 32'(done), 32'd0);
        cmp("rst_err", 0, 32'(err), 32'd0);
        cmp("rst_sweeps", 0, 32'(sweeps), 32'd0);
        @(negedge clk);
        #1;
        cmp("rst_count", 0, 32'(cnt), 32'd0);

        // fresh run after reset: done seven cycles after start
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            #1;
            if (done) begin
                n = i;
                break;
            end
            @(negedge clk);
        end
        cmp("post_rst_done_cycle", 0, 32'(n), 32'd7);
        cmp("post_rst_sweeps", 0, 32'(sweeps), 32'd1);
        cmp("post_rst_count", 0, 32'(cnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
